uart_boot_loader: RTL and testbench

Serial program loader placed between the board pins and `Grande_Risco_5_SOC` in FPGA tops. It holds the CPU in reset, receives a framed program image over UART, and writes it word by word into SoC instruction/data memory through a write port. It checks the image with a checksum, answers the host with ACK or NAK, and releases the CPU on success. The UART receive path is the writer feeding memory; the CPU is the reader.

---
 rtl/uart_boot_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART program loader: receives a framed image, writes it into SoC memory,
// answers ACK/NAK and releases the CPU from reset once the image checks out.
module uart_boot_loader #(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned MEMORY_SIZE = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        error
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned MAX_WORDS    = MEMORY_SIZE / 4;
    localparam logic [7:0]  SYNC_BYTE    = 8'hB0;
    localparam logic [7:0]  ACK_BYTE     = 8'h06;
    localparam logic [7:0]  NAK_BYTE     = 8'h15;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_st;
    logic [2:0]       rx_sync;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             rx_s;
    logic             rx_fall;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_sync[2] & ~rx_sync[1];

    // Bits sampled mid-period; a start that is high again at half-bit is a glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync    <= 3'b111;
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[1:0], rx};
            byte_valid <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) rx_st <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                        else                rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt     <= '0;
                        rx_st      <= RX_IDLE;
                        byte_valid <= rx_s;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // ---------------- UART transmitter ----------------
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    tx_state_t        tx_st;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_shift;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_done;

    // tx_shift holds {stop, data}; tx_bit 0 is the start bit, 9 the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st    <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_st)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        tx_shift <= {1'b1, tx_data};
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= 1'b0;
                        tx_st    <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx      <= 1'b1;
                            tx_done <= 1'b1;
                            tx_st   <= TX_IDLE;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // ---------------- Loader FSM ----------------
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, REPLY, RUN} state_t;

    state_t      state;
    logic [31:0] word_total;
    logic [31:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  checksum;
    logic [23:0] asm_word;
    logic        reply_ack;
    logic [31:0] next_word;

    // Three previous bytes plus the incoming one form the little-endian word
    assign next_word = {rx_byte, asm_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_total <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            asm_word   <= '0;
            reply_ack  <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                        checksum <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (byte_valid) begin
                        asm_word <= next_word[31:8];
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (next_word == 32'd0 || next_word > 32'(MAX_WORDS)) begin
                                tx_start  <= 1'b1;
                                tx_data   <= NAK_BYTE;
                                reply_ack <= 1'b0;
                                error     <= 1'b1;
                                state     <= REPLY;
                            end else begin
                                word_total <= next_word;
                                state      <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        checksum <= checksum ^ rx_byte;
                        asm_word <= next_word[31:8];
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {word_idx[29:0], 2'b00};
                            mem_wdata <= next_word;
                            word_idx  <= word_idx + 32'd1;
                            if (word_idx + 32'd1 == word_total) state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (byte_valid) begin
                        tx_start <= 1'b1;
                        state    <= REPLY;
                        if (rx_byte == checksum) begin
                            tx_data   <= ACK_BYTE;
                            reply_ack <= 1'b1;
                        end else begin
                            tx_data   <= NAK_BYTE;
                            reply_ack <= 1'b0;
                            error     <= 1'b1;
                        end
                    end
                end
                REPLY: begin
                    if (tx_done) begin
                        busy <= 1'b0;
                        if (reply_ack) begin
                            cpu_rst_n <= 1'b1;
                            state     <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RUN: begin
                    cpu_rst_n <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: UART byte driver, TX reply decoder,
// memory-write capture and a table of load scenarios plus corner sequences.
module tb_uart_boot_loader;

    localparam int unsigned CF  = 3200000;
    localparam int unsigned BR  = 100000;
    localparam int unsigned CPB = CF / BR;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          tx_falls = 0;

    typedef struct {
        bit          rst_first;
        logic [31:0] count;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;
        logic [7:0]  exp_reply;
        logic        exp_cpu;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    uart_boot_loader #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .MEMORY_SIZE(8192)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Decode host-bound frames, sampling mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            tx_falls++;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(b);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_mon();
        tx_q.delete();
        wa_q.delete();
        wd_q.delete();
        tx_falls = 0;
    endtask

    task automatic wait_reply(input string name, output logic [7:0] b);
        int got = 0;
        b = 8'hxx;
        for (int c = 0; c < 20 * CPB && got == 0; c++) begin
            @(negedge clk);
            if (tx_q.size() > 0) got = 1;
        end
        check({name, "_reply_seen"}, 32'(got), 32'd1);
        if (got != 0) b = tx_q.pop_front();
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [7:0]  csum = 8'h00;
        logic [7:0]  rep;
        logic [31:0] w;
        int          nw;
        if (v.rst_first) do_reset();
        clear_mon();
        nw = (v.count != 0 && v.count <= 32'd2048) ? int'(v.count) : 0;
        send_byte(8'hB0, 1'b1);
        check({name, "_busy_after_sync"}, 32'(busy), 32'd1);
        check({name, "_err_after_sync"}, 32'(error), 32'd0);
        send_word(v.count);
        for (int i = 0; i < nw; i++) begin
            w = (i == 0) ? v.w0 : v.w1;
            send_word(w);
            csum = csum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        if (nw != 0) send_byte(csum ^ v.flip, 1'b1);
        wait_reply(name, rep);
        check({name, "_reply"}, 32'(rep), 32'(v.exp_reply));
        check({name, "_cpu_in_stop"}, 32'(cpu_rst_n), 32'd0);
        repeat (CPB / 2 + 3) @(negedge clk);
        check({name, "_cpu_after"}, 32'(cpu_rst_n), 32'(v.exp_cpu));
        check({name, "_error"}, 32'(error), 32'(v.exp_err));
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_nwrites"}, 32'(wa_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            check({name, "_addr"}, wa_q[i], 32'(i * 4));
            check({name, "_data"}, wd_q[i], (i == 0) ? v.w0 : v.w1);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd2,     32'h12345678, 32'hDEADBEEF, 8'h00, 8'h06, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'd2,     32'h12345678, 32'hDEADBEEF, 8'h01, 8'h15, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'd2,     32'hCAFEF00D, 32'h00000001, 8'h00, 8'h06, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h801,   32'h0,        32'h0,        8'h00, 8'h15, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'd0,     32'h0,        32'h0,        8'h00, 8'h15, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'd1,     32'hA5A50F0F, 32'h0,        8'h00, 8'h06, 1'b1, 1'b0};

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // A short low glitch must not open a frame that would swallow the next byte
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'hB0, 1'b1);
        check("glitch_then_sync_busy", 32'(busy), 32'd1);
        do_reset();

        // Framing error on the sync byte and a stray byte leave the loader idle
        clear_mon();
        send_byte(8'hB0, 1'b0);
        check("bad_stop_busy", 32'(busy), 32'd0);
        send_byte(8'h55, 1'b1);
        check("garbage_busy", 32'(busy), 32'd0);
        check("noise_no_tx", 32'(tx_falls), 32'd0);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // RUN ignores everything on rx
        clear_mon();
        send_byte(8'hB0, 1'b1);
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 1'b1);
        repeat (12 * CPB) @(negedge clk);
        check("run_no_writes", 32'(wa_q.size()), 32'd0);
        check("run_no_tx", 32'(tx_falls), 32'd0);
        check("run_cpu", 32'(cpu_rst_n), 32'd1);
        check("run_busy", 32'(busy), 32'd0);

        // Reset after the sixth data byte, then a clean reload from address 0
        do_reset();
        clear_mon();
        send_byte(8'hB0, 1'b1);
        send_word(32'd2);
        send_word(32'h12345678);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        check("midload_busy", 32'(busy), 32'd1);
        check("midload_one_write", 32'(wa_q.size()), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_cpu", 32'(cpu_rst_n), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_vec("reload", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
